// File: rtl/trng_pkg.sv
// Shared types, constants and helpers for the TRNG word collector.
package trng_pkg;

  // Collector FSM encoding.
  typedef logic [2:0] collector_state_e;

  localparam collector_state_e ST_IDLE  = 3'd0;
  localparam collector_state_e ST_TRIG  = 3'd1;
  localparam collector_state_e ST_ARM   = 3'd2;
  localparam collector_state_e ST_WAIT  = 3'd3;
  localparam collector_state_e ST_CHECK = 3'd4;
  localparam collector_state_e ST_FAIL  = 3'd5;

  // Bit positions inside fail_cause.
  localparam int FAIL_RCT_BIT = 0;
  localparam int FAIL_APT_BIT = 1;

  // Default configuration.
  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_REP_LIMIT      = 3;
  localparam int DEF_APT_WINDOW     = 16;
  localparam int DEF_APT_LO         = 200;
  localparam int DEF_APT_HI         = 312;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // Number of set bits in a 32-bit word (0..32).
  function automatic logic [5:0] popcount32(input logic [31:0] w);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, w[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/trng_fifo.sv
// Small synchronous first-word-fall-through FIFO.
// rd_data presents the head whenever the FIFO is not empty and reads as zero
// when empty, so the storage array itself needs no reset.
module trng_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == FULL_LVL);
  assign level   = count;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage write; data path carries no reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trng_collector.sv
// TRNG consumer: triggers the sampler, captures each word, runs the
// repetition-count and adaptive-proportion health tests, and queues passing
// words in a FWFT FIFO. Any health failure stops harvesting until fail_clr.
module trng_collector
  import trng_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int REP_LIMIT      = DEF_REP_LIMIT,
  parameter int APT_WINDOW     = DEF_APT_WINDOW,
  parameter int APT_LO         = DEF_APT_LO,
  parameter int APT_HI         = DEF_APT_HI,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          fail_clr,
  output logic                          smp_trig,
  output logic                          smp_clear,
  input  logic [31:0]                   smp_data,
  input  logic                          smp_valid,
  input  logic                          rd_en,
  output logic [31:0]                   rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          health_fail,
  output logic [1:0]                    fail_cause,
  output logic                          timeout_err,
  output logic [31:0]                   words_ok
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam int WIN_W = $clog2(APT_WINDOW + 1);

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(APT_WINDOW);
  localparam logic [9:0]       APT_LO_V = 10'(APT_LO);
  localparam logic [9:0]       APT_HI_V = 10'(APT_HI);

  // Repetition counter never needs to count past the limit.
  function automatic logic [REP_W-1:0] sat_inc(input logic [REP_W-1:0] v);
    return (v == REP_MAX) ? v : v + 1'b1;
  endfunction

  collector_state_e state_q;
  collector_state_e state_d;

  logic [31:0]      word_q;
  logic [31:0]      prev_word;
  logic             prev_vld;
  logic [REP_W-1:0] rep_cnt;
  logic [9:0]       apt_sum;
  logic [WIN_W-1:0] apt_cnt;
  logic [TO_W-1:0]  to_cnt;

  logic [REP_W-1:0] rep_next;
  logic [9:0]       apt_sum_next;
  logic [WIN_W-1:0] apt_cnt_next;
  logic             apt_end;
  logic             rct_fail;
  logic             apt_fail;
  logic             check_fail;
  logic [1:0]       cause_new;

  logic             in_check;
  logic             capture;
  logic             timeout_hit;
  logic             push;
  logic             fifo_empty;
  logic             fifo_full;

  assign in_check    = (state_q == ST_CHECK);
  assign capture     = (state_q == ST_WAIT) && enable && smp_valid;
  assign timeout_hit = (state_q == ST_WAIT) && enable && !smp_valid && (to_cnt == TO_LAST);
  assign push        = in_check && !check_fail;
  assign smp_trig    = (state_q == ST_TRIG);
  assign rd_valid    = !fifo_empty;

  // Health test evaluation on the captured word.
  always_comb begin
    rep_next     = (prev_vld && (word_q == prev_word)) ? sat_inc(rep_cnt) : REP_W'(1);
    rct_fail     = (rep_next >= REP_MAX);
    apt_sum_next = apt_sum + 10'(popcount32(word_q));
    apt_cnt_next = apt_cnt + 1'b1;
    apt_end      = (apt_cnt_next == WIN_LAST);
    apt_fail     = apt_end && ((apt_sum_next < APT_LO_V) || (apt_sum_next > APT_HI_V));
    check_fail   = rct_fail || apt_fail;
    cause_new               = '0;
    cause_new[FAIL_RCT_BIT] = rct_fail;
    cause_new[FAIL_APT_BIT] = apt_fail;
  end

  // Next-state logic for the harvest handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable && !fifo_full && !health_fail) state_d = ST_TRIG;
      ST_TRIG:  state_d = ST_ARM;
      ST_ARM:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (!enable)                 state_d = ST_IDLE;
        else if (smp_valid)          state_d = ST_CHECK;
        else if (to_cnt == TO_LAST)  state_d = ST_IDLE;
      end
      ST_CHECK: state_d = check_fail ? ST_FAIL : ST_IDLE;
      ST_FAIL:  if (fail_clr) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Wait-for-valid timeout counter, restarted on the guard cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    to_cnt <= '0;
    else if (state_q == ST_ARM)    to_cnt <= '0;
    else if (state_q == ST_WAIT)   to_cnt <= to_cnt + 1'b1;
  end

  // Captured word and last-checked word; data only, no reset.
  always_ff @(posedge clk) begin
    if (capture)  word_q    <= smp_data;
    if (in_check) prev_word <= word_q;
  end

  // RCT/APT running state; a CHECK update takes priority over fail_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt  <= '0;
      prev_vld <= 1'b0;
      apt_sum  <= '0;
      apt_cnt  <= '0;
    end else if (in_check) begin
      rep_cnt  <= rep_next;
      prev_vld <= 1'b1;
      apt_sum  <= apt_end ? '0 : apt_sum_next;
      apt_cnt  <= apt_end ? '0 : apt_cnt_next;
    end else if (fail_clr) begin
      rep_cnt  <= '0;
      prev_vld <= 1'b0;
      apt_sum  <= '0;
      apt_cnt  <= '0;
    end
  end

  // Sticky health flags; a failure in the same cycle as fail_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      health_fail <= 1'b0;
      fail_cause  <= '0;
    end else if (in_check && check_fail) begin
      health_fail <= 1'b1;
      fail_cause  <= fail_clr ? cause_new : (fail_cause | cause_new);
    end else if (fail_clr) begin
      health_fail <= 1'b0;
      fail_cause  <= '0;
    end
  end

  // Timeout flag and the one-cycle sampler clear that accompanies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
      smp_clear   <= 1'b0;
    end else begin
      smp_clear <= timeout_hit;
      if (timeout_hit)   timeout_err <= 1'b1;
      else if (fail_clr) timeout_err <= 1'b0;
    end
  end

  // Count of words accepted into the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    words_ok <= '0;
    else if (push) words_ok <= words_ok + 32'd1;
  end

  trng_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (word_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

endmodule

// File: doc/trng_collector.md
Name: trng_collector

Overview:
- Consumer end of the TRNG sampler handshake. Drives sample_trig and clear, waits for valid, and captures each 32-bit random word.
- Runs continuous health tests on every word: a repetition count test (RCT) and an adaptive proportion test (APT).
- Pushes passing words into a small first-word-fall-through FIFO read by the CPU-side register block.
- Stops harvesting and latches a sticky fault on any health failure.

Parameters:
- FIFO_DEPTH, 8: FIFO entries; power of 2, at least 2.
- REP_LIMIT, 3: number of consecutive identical words that fails the RCT.
- APT_WINDOW, 16: words per APT window.
- APT_LO, 200: minimum total ones per window, inclusive.
- APT_HI, 312: maximum total ones per window, inclusive.
- TIMEOUT_CYCLES, 4096: maximum clk cycles spent waiting for smp_valid.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  harvest words while high.
- fail_clr  in  1  one-cycle pulse; clears the sticky flags and all health-test state.
- smp_trig  out  1  sampler trigger; one-cycle high pulse per word.
- smp_clear  out  1  one-cycle sampler clear, issued on timeout.
- smp_data  in  32  sampler random word.
- smp_valid  in  1  sampler word ready; level signal, stays high until the next trigger.
- rd_en  in  1  pop request.
- rd_data  out  32  FIFO head.
- rd_valid  out  1  FIFO not empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- health_fail  out  1  sticky health failure.
- fail_cause  out  2  sticky cause: bit0 = RCT, bit1 = APT.
- timeout_err  out  1  sticky timeout flag.
- words_ok  out  32  count of words pushed; wraps.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; RCT and APT state cleared.
- FSM states: IDLE, TRIG, ARM, WAIT, CHECK, FAIL.
  - IDLE: go to TRIG when enable && fifo_level<FIFO_DEPTH && !health_fail.
  - TRIG: smp_trig=1 for exactly one cycle, then go to ARM.
  - ARM: one guard cycle; smp_valid is ignored because the sampler's stale valid clears on this edge. Then go to WAIT and zero the timeout counter.
  - WAIT:
    - If enable drops: abandon the word and return to IDLE.
    - Else if smp_valid: register smp_data into word_q and go to CHECK.
    - Else if the counter reaches TIMEOUT_CYCLES-1: pulse smp_clear for one cycle, set timeout_err, return to IDLE (retry follows automatically).
  - CHECK: evaluate the tests on word_q in one cycle.
    - Pass: push word_q, increment words_ok, go to IDLE.
    - Fail: discard the word, set health_fail and the cause bit(s), go to FAIL.
  - FAIL: no triggers. fail_clr returns the FSM to IDLE.
- Latency: smp_valid sampled high in WAIT → word visible on rd_data 2 cycles later (CHECK, then the FIFO write edge) when the FIFO was empty.
- RCT:
  - prev_word and prev_vld registers track the last checked word.
  - If prev_vld && word_q==prev_word, rep_cnt increments; otherwise rep_cnt is set to 1.
  - Fail when the new rep_cnt ≥ REP_LIMIT.
  - prev_word is updated on every CHECK, pass or fail.
- APT:
  - Accumulate popcount(word_q) into a 10-bit sum and increment the window counter.
  - On the APT_WINDOW-th word, test APT_LO ≤ sum ≤ APT_HI, then reset the sum and counter.
  - Earlier words in the window are not retracted.
- Both tests failing together sets fail_cause=11.
- fail_clr:
  - Clears health_fail, fail_cause, timeout_err, rep_cnt, prev_vld, the APT sum and the window counter.
  - Valid in any state; only FAIL changes state.
  - If fail_clr coincides with a CHECK failure, the failure wins.
- FIFO:
  - First-word-fall-through: rd_data is the head whenever rd_valid=1.
  - rd_en while empty is ignored.
  - Push and pop in the same cycle leave the level unchanged.
  - Push is never attempted while full; IDLE gates on level.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: any state returns to IDLE, the FIFO empties, smp_trig drops to 0 immediately.

Decomposition:
- Package trng_pkg holds:
  - state enum collector_state_e (IDLE..FAIL).
  - constants FAIL_RCT_BIT=0 and FAIL_APT_BIT=1.
  - default localparams for the parameters above.
- Sub-module trng_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, rst_n, wr_en, wr_data, rd_en, rd_data, empty, full, level.
- The collector holds the FSM, the health tests and the timeout counter.

Test Plan:
1. Basic word: enable=1; sampler model asserts smp_valid 40 cycles after the trigger with 0xA5A51234 → one single-cycle smp_trig, then rd_valid=1, rd_data=0xA5A51234, words_ok=1, fifo_level=1.
2. RCT fail: three consecutive words of 0xDEADBEEF, bench popping → first two pushed, third discarded; health_fail=1, fail_cause=01, no further smp_trig for 100 cycles. A fail_clr pulse → smp_trig resumes within 2 cycles.
3. APT fail: 16 words alternating 0xFFFFFFFF/0xFFFFFFFE (sum 504), bench popping → 15 words pushed, fail_cause=10 after the 16th CHECK.
4. FIFO full: no pops, 8 distinct words → fifo_level=8, smp_trig held low. One rd_en → level 7, then exactly one more trigger and the level returns to 8.
5. Timeout: smp_valid held 0 → smp_clear pulses once 4096 cycles after ARM, timeout_err=1, new smp_trig follows; timeout_err stays set until fail_clr.
6. Reset mid-WAIT: assert rst_n=0 with 3 words queued → smp_trig=0, rd_valid=0, fifo_level=0, words_ok=0, all flags 0.
